// File: rtl/population_counter.sv
// Counts live cells written by life_logic during a generation and publishes
// population, generation number and extinct/stable/overflow status.
module population_counter #(
  parameter int DATA_WIDTH  = 16,
  parameter int POP_WIDTH   = 20,
  parameter int GEN_WIDTH   = 16,
  parameter int STABLE_GENS = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start_in,
  input  logic                  wr_en_in,
  input  logic [DATA_WIDTH-1:0] data_w_in,
  input  logic                  done_in,
  output logic [POP_WIDTH-1:0]  population_out,
  output logic [GEN_WIDTH-1:0]  generation_out,
  output logic                  valid_out,
  output logic                  extinct_out,
  output logic                  stable_out,
  output logic                  overflow_out
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam int RUN_W = $clog2(STABLE_GENS + 1);
  localparam logic [POP_WIDTH-1:0] POP_MAX = '1;
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_GENS);

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    DRAIN,
    PUBLISH
  } state_t;

  state_t                state;
  logic                  drain_cnt;
  logic                  done_q;
  logic                  done_rise;
  logic                  restart;
  logic                  capture;

  logic                  s0_v;
  logic [DATA_WIDTH-1:0] s0_data;
  logic [CNT_W-1:0]      s0_ones;
  logic                  s1_v;
  logic [CNT_W-1:0]      s1_cnt;

  logic [POP_WIDTH-1:0]  acc;
  logic                  ovf;
  logic [POP_WIDTH:0]    acc_sum;
  logic                  acc_sat;
  logic [POP_WIDTH-1:0]  acc_next;

  logic [POP_WIDTH-1:0]  prev_pop;
  logic [RUN_W-1:0]      run;
  logic [RUN_W-1:0]      run_next;

  assign done_rise = done_in & ~done_q;
  assign restart   = start_in & ((state == IDLE) | (state == COUNT));
  assign capture   = (state == COUNT) & wr_en_in & ~start_in;

  always_comb begin
    s0_ones = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      s0_ones = s0_ones + CNT_W'(s0_data[i]);
    end
  end

  assign acc_sum  = {1'b0, acc} + (POP_WIDTH + 1)'(s1_cnt);
  assign acc_sat  = acc_sum[POP_WIDTH];
  assign acc_next = acc_sat ? POP_MAX : acc_sum[POP_WIDTH-1:0];

  always_comb begin
    run_next = '0;
    if (acc == prev_pop) begin
      run_next = (run == RUN_MAX) ? run : run + 1'b1;
    end
  end

  // Capture/popcount/accumulate pipeline
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      done_q  <= 1'b0;
      s0_v    <= 1'b0;
      s0_data <= '0;
      s1_v    <= 1'b0;
      s1_cnt  <= '0;
      acc     <= '0;
      ovf     <= 1'b0;
    end else begin
      done_q  <= done_in;
      s0_v    <= capture;
      s0_data <= data_w_in;
      s1_v    <= s0_v & ~restart;
      s1_cnt  <= s0_v ? s0_ones : '0;
      if (restart) begin
        acc <= '0;
        ovf <= 1'b0;
      end else if (s1_v) begin
        acc <= acc_next;
        ovf <= ovf | acc_sat;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state          <= IDLE;
      drain_cnt      <= 1'b0;
      population_out <= '0;
      generation_out <= '0;
      valid_out      <= 1'b0;
      extinct_out    <= 1'b0;
      stable_out     <= 1'b0;
      overflow_out   <= 1'b0;
      prev_pop       <= '0;
      run            <= '0;
    end else begin
      valid_out <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_in) state <= COUNT;
        end
        COUNT: begin
          // A coincident start wins and swallows the done edge
          if (!start_in && done_rise) begin
            state     <= DRAIN;
            drain_cnt <= 1'b0;
          end
        end
        DRAIN: begin
          if (drain_cnt) state <= PUBLISH;
          else drain_cnt <= 1'b1;
        end
        PUBLISH: begin
          population_out <= acc;
          overflow_out   <= ovf;
          generation_out <= generation_out + 1'b1;
          extinct_out    <= (acc == '0);
          valid_out      <= 1'b1;
          run            <= run_next;
          prev_pop       <= acc;
          stable_out     <= (run_next == RUN_MAX);
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_population_counter.sv
// Bench for population_counter: directed table, corner sequences and
// randomized generations against a per-generation arithmetic model.
module tb_population_counter;

  logic        clk = 1'b0;
  logic        rst_in = 1'b1;
  logic        start_in = 1'b0;
  logic        wr_en_in = 1'b0;
  logic [15:0] data_w_in = '0;
  logic        done_in = 1'b0;

  logic [19:0] pop_o;
  logic [15:0] gen_o;
  logic        valid_o, ext_o, stb_o, ovf_o;
  logic [3:0]  pop4;
  logic [15:0] gen4;
  logic        valid4, ext4, stb4, ovf4;

  int checks = 0;
  int failures = 0;

  int m_gen[2];
  int m_prev[2];
  int m_run[2];
  int m_max[2] = '{1048575, 15};

  typedef struct {
    logic [3:0][15:0] w;
    int n;
    int pop;
    int gen;
    bit ext;
    bit stb;
  } vec_t;

  vec_t tbl[8];

  always #5 clk = ~clk;

  population_counter dut (
    .clk_in(clk), .rst_in(rst_in), .start_in(start_in),
    .wr_en_in(wr_en_in), .data_w_in(data_w_in), .done_in(done_in),
    .population_out(pop_o), .generation_out(gen_o),
    .valid_out(valid_o), .extinct_out(ext_o),
    .stable_out(stb_o), .overflow_out(ovf_o)
  );

  population_counter #(.POP_WIDTH(4)) dut4 (
    .clk_in(clk), .rst_in(rst_in), .start_in(start_in),
    .wr_en_in(wr_en_in), .data_w_in(data_w_in), .done_in(done_in),
    .population_out(pop4), .generation_out(gen4),
    .valid_out(valid4), .extinct_out(ext4),
    .stable_out(stb4), .overflow_out(ovf4)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0][15:0] w, input int n,
                              input int pop, input int gen,
                              input bit ext, input bit stb);
    vec_t v;
    v.w = w; v.n = n; v.pop = pop; v.gen = gen; v.ext = ext; v.stb = stb;
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_gen[k] = 0; m_prev[k] = 0; m_run[k] = 0;
    end
  endtask

  task automatic publish_check(input int raw);
    for (int k = 0; k < 2; k++) begin
      int pop, ovf;
      pop = (raw > m_max[k]) ? m_max[k] : raw;
      ovf = (raw > m_max[k]) ? 1 : 0;
      if (pop == m_prev[k]) m_run[k] = (m_run[k] >= 4) ? 4 : m_run[k] + 1;
      else m_run[k] = 0;
      m_prev[k] = pop;
      m_gen[k] = (m_gen[k] + 1) % 65536;
      if (k == 0) begin
        chk("pop", int'(pop_o), pop);
        chk("gen", int'(gen_o), m_gen[k]);
        chk("extinct", int'(ext_o), int'(pop == 0));
        chk("stable", int'(stb_o), int'(m_run[k] == 4));
        chk("overflow", int'(ovf_o), ovf);
      end else begin
        chk("pop4", int'(pop4), pop);
        chk("gen4", int'(gen4), m_gen[k]);
        chk("extinct4", int'(ext4), int'(pop == 0));
        chk("stable4", int'(stb4), int'(m_run[k] == 4));
        chk("overflow4", int'(ovf4), ovf);
      end
    end
  endtask

  task automatic start_pulse(input bit with_write);
    start_in = 1'b1;
    wr_en_in = with_write;
    data_w_in = 16'hFFFF;
    @(posedge clk); #1;
    start_in = 1'b0;
    wr_en_in = 1'b0;
  endtask

  task automatic write_word(input logic [15:0] w);
    wr_en_in = 1'b1;
    data_w_in = w;
    @(posedge clk); #1;
    wr_en_in = 1'b0;
  endtask

  // Raises done (any write already driven this cycle rides along with it)
  task automatic finish_gen(input int raw);
    int idx;
    idx = -1;
    done_in = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i >= 1) wr_en_in = 1'b0;
      if (valid_o) begin
        idx = i;
        break;
      end
    end
    chk("latency", idx, 4);
    if (idx >= 0) begin
      chk("valid_sync", int'(valid4), 1);
      publish_check(raw);
    end
    @(negedge clk);
    chk("valid_pulse", int'(valid_o | valid4), 0);
    done_in = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic no_valid(input string name, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (valid_o || valid4) seen++;
    end
    chk(name, seen, 0);
  endtask

  initial begin
    int raw;
    tbl[0] = mk({16'h0, 16'h8000, 16'h0001, 16'hFFFF}, 3, 18, 1, 0, 0);
    tbl[1] = mk('0, 0, 0, 2, 1, 0);
    tbl[2] = mk({48'h0, 16'h000F}, 1, 4, 3, 0, 0);
    tbl[3] = mk({48'h0, 16'h000F}, 1, 4, 4, 0, 0);
    tbl[4] = mk({48'h0, 16'h000F}, 1, 4, 5, 0, 0);
    tbl[5] = mk({48'h0, 16'h000F}, 1, 4, 6, 0, 0);
    tbl[6] = mk({48'h0, 16'h000F}, 1, 4, 7, 0, 1);
    tbl[7] = mk({48'h0, 16'h001F}, 1, 5, 8, 0, 0);

    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_in = 1'b0;
    @(negedge clk);
    chk("reset_outputs",
        int'({pop_o, gen_o, valid_o, ext_o, stb_o, ovf_o} != '0), 0);
    chk("reset_outputs4",
        int'({pop4, gen4, valid4, ext4, stb4, ovf4} != '0), 0);
    @(posedge clk); #1;

    for (int e = 0; e < 8; e++) begin
      raw = 0;
      start_pulse(0);
      for (int j = 0; j < tbl[e].n; j++) begin
        write_word(tbl[e].w[j]);
        raw += $countones(tbl[e].w[j]);
      end
      finish_gen(raw);
      chk("tbl_pop", int'(pop_o), tbl[e].pop);
      chk("tbl_gen", int'(gen_o), tbl[e].gen);
      chk("tbl_extinct", int'(ext_o), int'(tbl[e].ext));
      chk("tbl_stable", int'(stb_o), int'(tbl[e].stb));
    end

    // Saturation in the narrow instance, then recovery
    start_pulse(0);
    write_word(16'hFFFF);
    write_word(16'hFFFF);
    finish_gen(32);
    chk("sat_pop4", int'(pop4), 15);
    chk("sat_ovf4", int'(ovf4), 1);
    chk("sat_pop", int'(pop_o), 32);
    start_pulse(0);
    write_word(16'h0100);
    finish_gen(1);
    chk("recover_pop4", int'(pop4), 1);
    chk("recover_ovf4", int'(ovf4), 0);

    // Writes and a done edge in IDLE do nothing
    done_in = 1'b1;
    for (int j = 0; j < 3; j++) write_word(16'hFFFF);
    no_valid("idle_done", 8);
    done_in = 1'b0;
    @(posedge clk); #1;
    start_pulse(1);
    write_word(16'h0001);
    finish_gen(1);
    chk("idle_writes_pop", int'(pop_o), 1);

    // Restart mid-COUNT discards earlier writes
    start_pulse(0);
    write_word(16'h00FF);
    write_word(16'h00FF);
    start_pulse(0);
    write_word(16'h0003);
    finish_gen(2);
    chk("restart_pop", int'(pop_o), 2);

    // start coinciding with done edge: done is discarded
    start_pulse(0);
    write_word(16'hFFFF);
    start_in = 1'b1;
    done_in = 1'b1;
    @(posedge clk); #1;
    start_in = 1'b0;
    no_valid("start_done_clash", 8);
    done_in = 1'b0;
    @(posedge clk); #1;
    write_word(16'h0007);
    finish_gen(3);
    chk("clash_pop", int'(pop_o), 3);

    // Reset in DRAIN
    start_pulse(0);
    write_word(16'h00FF);
    done_in = 1'b1;
    @(posedge clk); #1;
    rst_in = 1'b1;
    @(posedge clk); #1;
    rst_in = 1'b0;
    @(negedge clk);
    chk("drain_reset",
        int'({pop_o, gen_o, valid_o, ext_o, stb_o, ovf_o} != '0), 0);
    no_valid("drain_reset_novalid", 8);
    done_in = 1'b0;
    @(posedge clk); #1;
    model_reset();
    start_pulse(0);
    write_word(16'h0001);
    finish_gen(1);
    chk("gen_after_reset", int'(gen_o), 1);

    // Randomized generations
    for (int g = 0; g < 40; g++) begin
      int nw;
      logic [15:0] w;
      bit coinc;
      nw = $urandom_range(0, 5);
      coinc = ($urandom_range(0, 1) == 1);
      raw = 0;
      start_pulse($urandom_range(0, 1) == 1);
      for (int j = 0; j < nw; j++) begin
        case ($urandom_range(0, 3))
          0: w = 16'hFFFF;
          1: w = 16'h0000;
          default: w = 16'($urandom);
        endcase
        raw += $countones(w);
        if ($urandom_range(0, 2) == 0) begin
          @(posedge clk); #1;
        end
        if (coinc && j == nw - 1) begin
          wr_en_in = 1'b1;
          data_w_in = w;
        end else begin
          write_word(w);
        end
      end
      finish_gen(raw);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
